alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters, e.g. the control-unit sequencer and the debug/test port. It arbitrates round-robin and registers the ALU operands and opcode. MUL and DIV get a multicycle settling window of configurable length; other ops get a short one. It captures the 64-bit result and returns it through a valid/ready response handshake to the requester that was granted.

Parameters:
LAT_SIMPLE, 1, ALU evaluation cycles for opcodes 0-5 and 8-12
MUL_LAT, 4, ALU evaluation cycles for MUL (opcode 6)
DIV_LAT, 8, ALU evaluation cycles for DIV (opcode 7)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester accept strobe, one-hot or zero
req_a0, req_b0  in  32 each  requester 0 operands
req_op0  in  4  requester 0 opcode
req_a1, req_b1  in  32 each  requester 1 operands
req_op1  in  4  requester 1 opcode
alu_a, alu_b  out  32 each  registered ALU operands
alu_op  out  4  registered ALU opcode
alu_result  in  64  ALU result; [63:32]=HI, [31:0]=LO
resp_valid  out  2  one-hot response valid to the granted requester
resp_ready  in  2  per-requester response accept
resp_data  out  64  captured result, shared by both requesters
resp_err  out  1  set with resp_valid when the opcode is reserved (13-15)
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, `clock`; reset `clear` is asynchronous and active-high.
- While `clear` is high:
  - State is IDLE.
  - alu_a, alu_b, alu_op, resp_data, resp_err, resp_valid and busy are all 0.
  - last_grant = 1, so requester 0 wins first.
  - req_ready is forced to 0.
- Opcodes: 0 OR, 1 AND, 2 NOT, 3 ADD, 4 SUB, 5 NEG, 6 MUL, 7 DIV, 8 SHL, 9 SHR, 10 SHRA, 11 ROL, 12 ROR. Opcodes 13-15 are reserved.
- The FSM has three states: IDLE, EXEC and DONE.
- IDLE:
  - grant = requester with req_valid high. If both are high, grant goes to the one that is not last_grant.
  - req_ready[grant] is combinationally high in this cycle (C0); the handshake completes at the C0 edge.
  - At that edge, the granted operands and opcode load into alu_a/alu_b/alu_op, and last_grant <= grant.
  - Valid opcode: the counter loads lat-1 and the FSM goes to EXEC. lat = MUL_LAT for 6, DIV_LAT for 7, LAT_SIMPLE otherwise.
  - Reserved opcode: alu_* are left unchanged, resp_data <= 0, resp_err <= 1, and the FSM goes to DONE. resp_valid is therefore seen in C1.
- EXEC:
  - alu_* are stable from C1 onward.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0 (cycle C_lat), alu_result is captured into resp_data, resp_err <= 0, and the FSM goes to DONE.
  - resp_valid is therefore first high in cycle C_lat+1; for LAT_SIMPLE=1 that is C2.
- DONE:
  - resp_valid[grant] is high. resp_data and resp_err are held stable until resp_ready[grant] is seen.
  - On that edge: resp_valid <= 0 and the FSM goes to IDLE.
  - A new request is accepted no earlier than the following cycle, so there is always one bubble.
  - resp_ready on the non-granted bit is ignored.
- Requests: req_valid may drop before acceptance without effect. No request is accepted outside IDLE; pending requesters wait.
- DIV convention: LO = quotient, HI = remainder. MUL gives the 64-bit signed product in HI:LO. A divide by zero is passed through unchecked; the result is whatever the ALU produces.
- `clear` asserted mid-EXEC or mid-DONE: everything returns to reset values immediately and the in-flight operation is dropped. The requester must reissue.
- alu_op/alu_a/alu_b hold their last values in IDLE; no zeroing between operations.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode constants (OP_OR..OP_ROR);
  - the IDLE/EXEC/DONE state encoding;
  - a function op_latency(op) returning lat-1 from the parameters;
  - a function op_reserved(op).
- Sub-module rr_arb2: a 2-input round-robin picker taking req[1:0] and last_grant, and producing a one-hot grant. It is combinational and reusable for the bus arbiter.

Test Plan:
1. After reset, req0 ADD a=20 b=5 -> req_ready=01 in C0; resp_valid=01 in C2; resp_data=25; resp_err=0; busy high C1-C2.
2. Both valid in the same cycle (req0 OR 20,5; req1 SUB 20,5) -> req0 is served first with 21, then req1 with 15. A second simultaneous pair is then served req1 first.
3. MUL 20*5 with MUL_LAT=4 -> resp_valid in C5, resp_data=0x0000000000000064. DIV 20/5 with DIV_LAT=8 -> resp_valid in C9, LO=4, HI=0. alu_op stays stable throughout EXEC.
4. resp_ready held low for 10 cycles with req1 pending -> resp_valid and resp_data stay stable and req_ready stays 00. Raise resp_ready -> IDLE on the next cycle, and req1 is accepted the cycle after the bubble.
5. req0 opcode 13 -> resp_valid=01 in C1, resp_err=1, resp_data=0, alu_op unchanged from its prior value.
6. Assert `clear` in the 4th EXEC cycle of a DIV -> busy, resp_valid and alu_* go to 0 immediately. After release, req0 is accepted, confirming last_grant was reset to 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter FSM encoding and per-opcode latency helpers
// for the ALU arbiter.
package alu_pkg;

   localparam int CNT_W = 16;

   localparam logic [3:0] OP_OR   = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_NEG  = 4'd5;
   localparam logic [3:0] OP_MUL  = 4'd6;
   localparam logic [3:0] OP_DIV  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_SHRA = 4'd10;
   localparam logic [3:0] OP_ROL  = 4'd11;
   localparam logic [3:0] OP_ROR  = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns the settling-window length minus one, i.e. the EXEC counter load value.
   function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op,
                                                   input int lat_simple,
                                                   input int mul_lat,
                                                   input int div_lat);
      int l;
      case (op)
         OP_MUL:  l = mul_lat;
         OP_DIV:  l = div_lat;
         default: l = lat_simple;
      endcase
      return CNT_W'(l - 1);
   endfunction

   function automatic logic op_reserved(input logic [3:0] op);
      return (op > OP_ROR);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: one-hot grant, ties go to the requester that
// was not granted last. Purely combinational.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11)
         o_grant = i_last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU: registers operands,
// waits a per-opcode settling window, then returns the result via valid/ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int LAT_SIMPLE = 1,
   parameter int MUL_LAT    = 4,
   parameter int DIV_LAT    = 8
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [3:0]  req_op0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [3:0]  req_op1,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [63:0] alu_result,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_err,
   output logic        busy
);

   state_t             r_state;
   state_t             w_next;
   logic               r_last_grant;
   logic               r_gidx;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_alu_a;
   logic [31:0]        r_alu_b;
   logic [3:0]         r_alu_op;
   logic [63:0]        r_resp_data;
   logic               r_resp_err;
   logic [1:0]         r_resp_valid;

   logic [1:0]         w_grant;
   logic               w_gidx;
   logic               w_accept;
   logic [31:0]        w_a;
   logic [31:0]        w_b;
   logic [3:0]         w_op;
   logic               w_reserved;
   logic               w_resp_hs;
   logic [1:0]         w_resp_onehot;

   rr_arb2 u_rr_arb2 (
      .i_req   (req_valid),
      .i_last  (r_last_grant),
      .o_grant (w_grant)
   );

   assign w_gidx        = w_grant[1];
   assign w_a           = w_gidx ? req_a1  : req_a0;
   assign w_b           = w_gidx ? req_b1  : req_b0;
   assign w_op          = w_gidx ? req_op1 : req_op0;
   assign w_reserved    = op_reserved(w_op);
   assign w_accept      = (r_state == ST_IDLE) && (w_grant != 2'b00);
   assign w_resp_onehot = r_gidx ? 2'b10 : 2'b01;
   // Only the granted requester's ready bit can retire the response.
   assign w_resp_hs     = resp_ready[r_gidx];

   assign req_ready  = (r_state == ST_IDLE && !clear) ? w_grant : 2'b00;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_err   = r_resp_err;
   assign busy       = (r_state != ST_IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = w_reserved ? ST_DONE : ST_EXEC;
         ST_EXEC: if (r_cnt == '0) w_next = ST_DONE;
         ST_DONE: if (w_resp_hs) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_gidx       <= 1'b0;
         r_cnt        <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
         r_resp_valid <= 2'b00;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_last_grant <= w_gidx;
                  r_gidx       <= w_gidx;
                  if (w_reserved) begin
                     // Reserved opcodes never touch the ALU; respond with an error at once.
                     r_resp_data  <= '0;
                     r_resp_err   <= 1'b1;
                     r_resp_valid <= w_grant;
                  end else begin
                     r_alu_a  <= w_a;
                     r_alu_b  <= w_b;
                     r_alu_op <= w_op;
                     r_cnt    <= op_latency(w_op, LAT_SIMPLE, MUL_LAT, DIV_LAT);
                  end
               end
            end
            ST_EXEC: begin
               if (r_cnt == '0) begin
                  r_resp_data  <= alu_result;
                  r_resp_err   <= 1'b0;
                  r_resp_valid <= w_resp_onehot;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (w_resp_hs)
                  r_resp_valid <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model
// closing the loop on alu_a/alu_b/alu_op -> alu_result.
module tb_alu_arbiter;

   logic        clock;
   logic        clear;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]  req_op0, req_op1;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [63:0] alu_result;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [63:0] resp_data;
   logic        resp_err;
   logic        busy;

   int checks;
   int failures;

   alu_arbiter #(.LAT_SIMPLE(1), .MUL_LAT(4), .DIV_LAT(8)) dut (
      .clock      (clock),
      .clear      (clear),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a0     (req_a0),
      .req_b0     (req_b0),
      .req_op0    (req_op0),
      .req_a1     (req_a1),
      .req_b1     (req_b1),
      .req_op1    (req_op1),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Environment ALU: only the opcodes the bench exercises need to be exact.
   always_comb begin
      alu_result = 64'd0;
      case (alu_op)
         4'd0: alu_result = {32'd0, alu_a | alu_b};
         4'd1: alu_result = {32'd0, alu_a & alu_b};
         4'd3: alu_result = {32'd0, alu_a + alu_b};
         4'd4: alu_result = {32'd0, alu_a - alu_b};
         4'd6: alu_result = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
         4'd7: alu_result = (alu_b == 32'd0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
         default: alu_result = 64'd0;
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic pulse_reset();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
      req_a0 = 32'd0; req_b0 = 32'd0; req_op0 = 4'd0;
      req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = 4'd0;
      tick(); tick();
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
      checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
      checks++; if ({resp_data, resp_err} !== 65'd0) begin failures++; $display("FAIL reset_resp got=%h/%b exp=0", resp_data, resp_err); end
      req_valid = 2'b00;
      clear = 1'b0;
      tick();
   endtask

   task automatic test_simple_add();
      req_a0 = 32'd20; req_b0 = 32'd5; req_op0 = 4'd3; req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_req_ready got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00; #1;
      checks++; if (busy !== 1'b1 || resp_valid !== 2'b00) begin failures++; $display("FAIL add_c1 busy=%b rv=%b exp 1/00", busy, resp_valid); end
      checks++; if (alu_a !== 32'd20 || alu_b !== 32'd5 || alu_op !== 4'd3) begin failures++; $display("FAIL add_alu_regs got=%0d/%0d/%0d exp=20/5/3", alu_a, alu_b, alu_op); end
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || busy !== 1'b1) begin failures++; $display("FAIL add_c2 rv=%b busy=%b exp=01/1", resp_valid, busy); end
      checks++; if (resp_data !== 64'd25 || resp_err !== 1'b0) begin failures++; $display("FAIL add_data got=%0d err=%b exp=25/0", resp_data, resp_err); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00; #1;
      checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL add_ack rv=%b busy=%b exp=00/0", resp_valid, busy); end
   endtask

   task automatic test_mul_div();
      req_a0 = 32'd20; req_b0 = 32'd5; req_op0 = 4'd6; req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mul_req_ready got=%b exp=01", req_ready); end
      for (int k = 1; k <= 4; k++) begin
         tick(); req_valid = 2'b00; #1;
         checks++; if (resp_valid !== 2'b00 || alu_op !== 4'd6) begin failures++; $display("FAIL mul_exec_c%0d rv=%b op=%0d exp=00/6", k, resp_valid, alu_op); end
      end
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'h0000_0000_0000_0064) begin failures++; $display("FAIL mul_c5 rv=%b data=%h exp=01/64", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00;
      req_op0 = 4'd7; req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL div_req_ready got=%b exp=01", req_ready); end
      for (int k = 1; k <= 8; k++) begin
         tick(); req_valid = 2'b00; #1;
         checks++; if (resp_valid !== 2'b00 || alu_op !== 4'd7) begin failures++; $display("FAIL div_exec_c%0d rv=%b op=%0d exp=00/7", k, resp_valid, alu_op); end
      end
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== {32'd0, 32'd4}) begin failures++; $display("FAIL div_c9 rv=%b data=%h exp=01/4", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00;
   endtask

   task automatic test_round_robin();
      pulse_reset();
      req_a0 = 32'd20; req_b0 = 32'd5; req_op0 = 4'd0;
      req_a1 = 32'd20; req_b1 = 32'd5; req_op1 = 4'd4;
      req_valid = 2'b11; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_pair1_first got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b10; #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_pending_wait got=%b exp=00", req_ready); end
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd21) begin failures++; $display("FAIL rr_req0_or rv=%b data=%0d exp=01/21", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00; #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_pair1_second got=%b exp=10", req_ready); end
      tick(); req_valid = 2'b00; tick(); #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== 64'd15) begin failures++; $display("FAIL rr_req1_sub rv=%b data=%0d exp=10/15", resp_valid, resp_data); end
      resp_ready = 2'b10; tick(); resp_ready = 2'b00;
      // Single req0 op leaves last_grant = 0 so the next tie favours req1.
      req_a0 = 32'd12; req_b0 = 32'd10; req_op0 = 4'd1; req_valid = 2'b01;
      tick(); req_valid = 2'b00; tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd8) begin failures++; $display("FAIL rr_single_and rv=%b data=%0d exp=01/8", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00;
      req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 4'd3;
      req_a1 = 32'd3; req_b1 = 32'd12; req_op1 = 4'd0;
      req_valid = 2'b11; #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_pair2_first got=%b exp=10", req_ready); end
      tick(); req_valid = 2'b01; tick(); #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== 64'd15) begin failures++; $display("FAIL rr_pair2_req1 rv=%b data=%0d exp=10/15", resp_valid, resp_data); end
      resp_ready = 2'b10; tick(); resp_ready = 2'b00; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_pair2_second got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00; tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd3) begin failures++; $display("FAIL rr_pair2_req0 rv=%b data=%0d exp=01/3", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00;
   endtask

   task automatic test_backpressure();
      req_a0 = 32'd7; req_b0 = 32'd8; req_op0 = 4'd3; req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
      tick();
      req_a1 = 32'd9; req_b1 = 32'd4; req_op1 = 4'd4; req_valid = 2'b11;
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd15) begin failures++; $display("FAIL bp_resp rv=%b data=%0d exp=01/15", resp_valid, resp_data); end
      // Non-granted ready bit must not retire the response.
      resp_ready = 2'b10;
      for (int k = 0; k < 10; k++) begin
         tick(); #1;
         checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd15 || req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold_%0d rv=%b data=%0d rr=%b exp=01/15/00", k, resp_valid, resp_data, req_ready); end
      end
      resp_ready = 2'b01; req_valid = 2'b10; tick(); resp_ready = 2'b00; #1;
      checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin failures++; $display("FAIL bp_release busy=%b rr=%b exp=0/10", busy, req_ready); end
      tick(); req_valid = 2'b00; tick(); #1;
      checks++; if (resp_valid !== 2'b10 || resp_data !== 64'd5) begin failures++; $display("FAIL bp_req1 rv=%b data=%0d exp=10/5", resp_valid, resp_data); end
      resp_ready = 2'b10; tick(); resp_ready = 2'b00;
   endtask

   task automatic test_reserved();
      req_a0 = 32'd99; req_b0 = 32'd1; req_op0 = 4'd13; req_valid = 2'b01; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rsv_accept got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00; #1;
      checks++; if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_data !== 64'd0) begin failures++; $display("FAIL rsv_c1 rv=%b err=%b data=%h exp=01/1/0", resp_valid, resp_err, resp_data); end
      checks++; if (alu_op !== 4'd4 || alu_a !== 32'd9) begin failures++; $display("FAIL rsv_alu_held op=%0d a=%0d exp=4/9", alu_op, alu_a); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00; #1;
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin failures++; $display("FAIL rsv_ack busy=%b rv=%b exp=0/00", busy, resp_valid); end
   endtask

   task automatic test_clear_mid_exec();
      req_a0 = 32'd100; req_b0 = 32'd7; req_op0 = 4'd7; req_valid = 2'b01;
      tick(); req_valid = 2'b00;
      tick(); tick(); tick();
      clear = 1'b1; req_valid = 2'b11;
      req_a0 = 32'd2; req_b0 = 32'd3; req_op0 = 4'd3;
      req_a1 = 32'd5; req_b1 = 32'd5; req_op1 = 4'd0;
      #1;
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL clr_ctrl busy=%b rv=%b rr=%b exp=0/00/00", busy, resp_valid, req_ready); end
      checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin failures++; $display("FAIL clr_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
      tick(); clear = 1'b0; #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL clr_last_grant got=%b exp=01", req_ready); end
      tick(); req_valid = 2'b00; #1;
      checks++; if (busy !== 1'b1 || alu_op !== 4'd3) begin failures++; $display("FAIL clr_reissue busy=%b op=%0d exp=1/3", busy, alu_op); end
      tick(); #1;
      checks++; if (resp_valid !== 2'b01 || resp_data !== 64'd5) begin failures++; $display("FAIL clr_result rv=%b data=%0d exp=01/5", resp_valid, resp_data); end
      resp_ready = 2'b01; tick(); resp_ready = 2'b00;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_simple_add();
      test_mul_div();
      test_round_robin();
      test_backpressure();
      test_reserved();
      test_clear_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
